// File: rtl/gpio_arb_pkg.sv
// Shared types and defaults for the GPIO output arbiter and its round-robin picker.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } arb_state_e;

   localparam int GPIO_ARB_WIDTH       = 8;
   localparam int GPIO_ARB_HOLD_CYCLES = 4;

   // Pads are undriven (enable-bar high) out of reset.
   localparam logic [GPIO_ARB_WIDTH-1:0] GPIO_ARB_OEB_RESET = '1;

   // Index width that stays legal when only one item exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_picker
   import gpio_arb_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [NREQ-1:0] rot;

   // Rotate so bit 0 is the pointer position; scan downward so the nearest hit wins.
   always_comb begin
      int s;
      s     = 0;
      valid = 1'b0;
      idx   = '0;
      rot   = NREQ'({req, req} >> ptr);
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            valid = 1'b1;
            idx   = IDX_W'(s);
         end
      end
   end

endmodule

// File: rtl/gpio_out_arbiter.sv
// Round-robin arbiter sharing the user output pins between on-chip requesters.
// Every grant holds the pins for at least HOLD_CYCLES so an off-chip monitor sees each write.
// Optional build macro GPIO_ARB_LOCK_EN adds a 'lock' input restricting service to requester 0.
module gpio_out_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int               NREQ        = 3,
   parameter int               WIDTH       = GPIO_ARB_WIDTH,
   parameter int               HOLD_CYCLES = GPIO_ARB_HOLD_CYCLES,
   parameter logic [WIDTH-1:0] OEB_RESET   = {WIDTH{GPIO_ARB_OEB_RESET[0]}}
) (
   input  logic                          clk,
   input  logic                          nrst,
`ifdef GPIO_ARB_LOCK_EN
   input  logic                          lock,
`endif
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*WIDTH-1:0]         wdata,
   input  logic [NREQ*WIDTH-1:0]         woeb,
   output logic [NREQ-1:0]               ack,
   output logic [WIDTH-1:0]              gpio_out,
   output logic [WIDTH-1:0]              gpio_oeb,
   output logic [idx_width(NREQ)-1:0]    owner,
   output logic                          busy
);

   localparam int               IDX_W    = idx_width(NREQ);
   localparam int               CNT_W    = idx_width(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   arb_state_e       state, state_nxt;
   logic [IDX_W-1:0] win_p0, win_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [NREQ-1:0]  elig;
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [NREQ-1:0]  ack_d;
   logic [WIDTH-1:0] wdata_a [NREQ];
   logic [WIDTH-1:0] woeb_a  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign wdata_a[g] = wdata[g*WIDTH +: WIDTH];
      assign woeb_a[g]  = woeb[g*WIDTH +: WIDTH];
   end

`ifdef GPIO_ARB_LOCK_EN
   // While locked only requester 0 can win; others stay pending, unacked.
   always_comb begin
      elig = req;
      if (lock) elig = req & NREQ'(1);
   end
`else
   assign elig = req;
`endif

   rr_picker #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (elig),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Next-state logic: arbitrate in IDLE, or at the end of HOLD so back-to-back writes skip IDLE.
   always_comb begin
      state_nxt = state;
      win_nxt   = win_p0;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               win_nxt   = pick_idx;
               state_nxt = GRANT;
            end
         end
         GRANT: state_nxt = HOLD;
         HOLD: begin
            if (hold_cnt == '0) begin
               if (pick_vld) begin
                  win_nxt   = pick_idx;
                  state_nxt = GRANT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pointer advance past the winner and the one-hot ack raised during GRANT.
   always_comb begin
      rr_nxt = (int'(win_p0) == NREQ - 1) ? '0 : win_p0 + 1'b1;
      ack_d  = '0;
      if (state == GRANT) ack_d[win_p0] = 1'b1;
   end

   // ---- stage p0: arbitration decision, pointer and hold timer ----
   // Control registers: FSM state, latched winner, rr pointer, dwell counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         win_p0   <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         state  <= state_nxt;
         win_p0 <= win_nxt;
         if (state == GRANT) begin
            rr_ptr   <= rr_nxt;
            hold_cnt <= CNT_LOAD;
         end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

   // ---- stage p1: pad drive ----
   // Pin value, enables, owner and ack update together so ack marks the new pin value.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         gpio_out <= '0;
         gpio_oeb <= OEB_RESET;
         owner    <= '0;
         ack      <= '0;
      end else begin
         ack <= ack_d;
         if (state == GRANT) begin
            gpio_out <= wdata_a[win_p0];
            gpio_oeb <= woeb_a[win_p0];
            owner    <= win_p0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Scoreboard bench for gpio_out_arbiter: a timing/fairness reference model predicts each grant,
// a monitor pops predictions whenever ack is seen and also checks that pins hold between grants.
module tb_gpio_out_arbiter;

   localparam int NREQ  = 3;
   localparam int WIDTH = 8;
   localparam int HOLD  = 4;

   logic                    clk = 1'b0;
   logic                    nrst;
   logic [NREQ-1:0]         req;
   logic [NREQ*WIDTH-1:0]   wdata;
   logic [NREQ*WIDTH-1:0]   woeb;
   logic [NREQ-1:0]         ack;
   logic [WIDTH-1:0]        gpio_out;
   logic [WIDTH-1:0]        gpio_oeb;
   logic [1:0]              owner;
   logic                    busy;
`ifdef GPIO_ARB_LOCK_EN
   logic                    lock;
`endif

   always #5 clk = ~clk;

   gpio_out_arbiter #(
      .NREQ        (NREQ),
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
`ifdef GPIO_ARB_LOCK_EN
      .lock     (lock),
`endif
      .req      (req),
      .wdata    (wdata),
      .woeb     (woeb),
      .ack      (ack),
      .gpio_out (gpio_out),
      .gpio_oeb (gpio_oeb),
      .owner    (owner),
      .busy     (busy)
   );

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic [7:0] oeb;
      int         due;
   } exp_t;

   exp_t sbq[$];
   int   ack_log[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   mcyc  = 0;
   int   grants [NREQ];
   bit   auto_re[NREQ];
   bit   rearm  [NREQ];
   bit   rnd_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a grant is decided at the first edge where something is eligible and the
   // previous dwell is over; its pins/ack appear one edge later; the next decision may happen
   // HOLD edges after that. Winner = first requester at or after the pointer, wrapping.
   initial begin : model
      int            ptr, next_ok, win;
      bit            pend;
      logic [NREQ-1:0] el;
      exp_t          e;
      ptr = 0; next_ok = 0; win = 0; pend = 0;
      forever begin
         @(posedge clk or negedge nrst);
         if (!nrst) begin
            ptr = 0; next_ok = 0; pend = 0;
            sbq.delete();
         end else begin
            mcyc++;
            if (pend) begin
               e.idx  = win;
               e.data = wdata[win*WIDTH +: WIDTH];
               e.oeb  = woeb[win*WIDTH +: WIDTH];
               e.due  = mcyc;
               sbq.push_back(e);
               pend = 0;
            end
            el = req;
`ifdef GPIO_ARB_LOCK_EN
            if (lock) el = req & 3'b001;
`endif
            if (mcyc >= next_ok && el != '0) begin
               for (int k = 0; k < NREQ; k++) begin
                  if (el[(ptr + k) % NREQ]) begin
                     win = (ptr + k) % NREQ;
                     break;
                  end
               end
               ptr     = (win + 1) % NREQ;
               pend    = 1;
               next_ok = mcyc + 1 + HOLD;
            end
         end
      end
   end

   // Monitor: compare each ack against the next prediction; otherwise pins must hold.
   initial begin : monitor
      logic [7:0] ep, eo;
      exp_t       e;
      ep = 8'h00; eo = 8'hFF;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            ep = 8'h00; eo = 8'hFF;
         end else if (ack != '0) begin
            if (sbq.size() == 0) begin
               check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               e = sbq.pop_front();
               check("ack_vec",     32'(ack),      32'(1) << e.idx);
               check("ack_cycle",   32'(mcyc),     32'(e.due));
               check("pins",        32'(gpio_out), 32'(e.data));
               check("oeb",         32'(gpio_oeb), 32'(e.oeb));
               check("owner",       32'(owner),    32'(e.idx));
               check("busy_on_ack", 32'(busy),     32'd1);
               ep = e.data; eo = e.oeb;
            end
         end else begin
            if (sbq.size() != 0 && sbq[0].due < mcyc) begin
               n_cmp++; n_err++;
               $display("FAIL missing_ack: got none, expected ack for requester %0d at cycle %0d",
                        sbq[0].idx, sbq[0].due);
               void'(sbq.pop_front());
            end
            check("pins_hold", 32'(gpio_out), 32'(ep));
            check("oeb_hold",  32'(gpio_oeb), 32'(eo));
         end
      end
   end

   task automatic present(input int i, input logic [7:0] d, input logic [7:0] o);
      req[i] = 1'b1;
      wdata[i*WIDTH +: WIDTH] = d;
      woeb[i*WIDTH +: WIDTH]  = o;
   endtask

   // One cycle of requester behaviour: drop on ack, optional re-present, optional random traffic.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            req[i] = 1'b0;
            grants[i]++;
            ack_log.push_back(i);
            rearm[i] = auto_re[i];
         end else if (rearm[i]) begin
            rearm[i] = 1'b0;
            present(i, 8'($urandom), 8'($urandom));
         end else if (rnd_en) begin
            if (!req[i] && $urandom_range(0, 3) == 0)
               present(i, 8'($urandom), 8'($urandom));
            else if (req[i] && $urandom_range(0, 15) == 0)
               req[i] = 1'b0;
         end
      end
   endtask

   task automatic wait_grant(input int i, input int bound);
      int g0, n;
      g0 = grants[i]; n = 0;
      while (grants[i] == g0 && n < bound) begin
         step();
         n++;
      end
      check("wait_grant", 32'(grants[i] - g0), 32'd1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] seq [12];
      int g1, n;
      for (int i = 0; i < NREQ; i++) begin
         grants[i] = 0; auto_re[i] = 0; rearm[i] = 0;
      end
      nrst = 1'b0; req = '0; wdata = '0; woeb = '1;
`ifdef GPIO_ARB_LOCK_EN
      lock = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_oeb",   32'(gpio_oeb), 32'hFF);
      check("rst_out",   32'(gpio_out), 32'h00);
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_ack",   32'(ack),      32'd0);
      check("rst_owner", 32'(owner),    32'd0);
      nrst = 1'b1;

      // Core-only counter sequence.
      for (int k = 0; k < 10; k++) seq[k] = 8'(k + 1);
      seq[10] = 8'hFF; seq[11] = 8'h00;
      for (int k = 0; k < 12; k++) begin
         present(0, seq[k], 8'h00);
         wait_grant(0, 20);
      end
      step();
      check("seq_last_out", 32'(gpio_out), 32'h00);
      check("seq_last_oeb", 32'(gpio_oeb), 32'h00);

      // Reset in the middle of HOLD, with another request pending.
      present(2, 8'h55, 8'h0F);
      wait_grant(2, 20);
      step();
      present(1, 8'h77, 8'h00);
      #2 nrst = 1'b0;
      #1;
      check("midrst_out",   32'(gpio_out), 32'h00);
      check("midrst_oeb",   32'(gpio_oeb), 32'hFF);
      check("midrst_busy",  32'(busy),     32'd0);
      check("midrst_owner", 32'(owner),    32'd0);
      req = '0;
      g1 = grants[1];
      for (int k = 0; k < 6; k++) begin
         step();
         check("rst_no_ack", 32'(ack), 32'd0);
      end
      nrst = 1'b1;
      repeat (8) step();
      check("rst_dropped_ack", 32'(grants[1] - g1), 32'd0);

      // Contention from all three at pointer 0.
      ack_log.delete();
      present(0, 8'hA0, 8'h00);
      present(1, 8'hB1, 8'h00);
      present(2, 8'hC2, 8'h00);
      n = 0;
      while (ack_log.size() < 3 && n < 40) begin step(); n++; end
      check("contention_count", 32'(ack_log.size()), 32'd3);
      if (ack_log.size() >= 3) begin
         check("order0", 32'(ack_log[0]), 32'd0);
         check("order1", 32'(ack_log[1]), 32'd1);
         check("order2", 32'(ack_log[2]), 32'd2);
      end
      check("contention_pins", 32'(gpio_out), 32'hC2);

      // Fairness between 0 and 2, both re-presenting right after each ack.
      ack_log.delete();
      auto_re[0] = 1; auto_re[2] = 1;
      present(0, 8'h10, 8'h00);
      present(2, 8'h20, 8'h00);
      repeat (40) step();
      auto_re[0] = 0; auto_re[2] = 0;
      rearm[0] = 0; rearm[2] = 0;
      n = 0;
      while (req != '0 && n < 40) begin step(); n++; end
      check("fair_drain", 32'(req), 32'd0);
      check("fair_enough", 32'(ack_log.size() >= 6), 32'd1);
      for (int k = 1; k < ack_log.size(); k++)
         check("fair_alternate", 32'(ack_log[k] != ack_log[k-1]), 32'd1);

      // Early withdraw during HOLD is never served.
      repeat (6) step();
      present(0, 8'h33, 8'h00);
      wait_grant(0, 20);
      step();
      g1 = grants[1];
      present(1, 8'h99, 8'h00);
      step();
      req[1] = 1'b0;
      repeat (10) step();
      check("withdraw_no_ack", 32'(grants[1] - g1), 32'd0);
      check("withdraw_pins",   32'(gpio_out),        32'h33);

`ifdef GPIO_ARB_LOCK_EN
      // Lock restricts service to requester 0 until released.
      lock = 1'b1;
      g1 = grants[1];
      present(0, 8'h11, 8'h00);
      present(1, 8'h22, 8'h00);
      wait_grant(0, 20);
      repeat (12) step();
      check("lock_blocks", 32'(grants[1] - g1), 32'd0);
      lock = 1'b0;
      wait_grant(1, 20);
      step();
      check("unlock_pins", 32'(gpio_out), 32'h22);
`endif

      // Randomized traffic with withdrawals.
      rnd_en = 1'b1;
      for (int k = 0; k < 400; k++) begin
`ifdef GPIO_ARB_LOCK_EN
         if ($urandom_range(0, 31) == 0) lock = ~lock;
`endif
         step();
      end
      rnd_en = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
      lock = 1'b0;
`endif
      n = 0;
      while ((req != '0 || sbq.size() != 0) && n < 100) begin step(); n++; end
      repeat (HOLD + 3) step();
      check("final_idle_busy", 32'(busy),       32'd0);
      check("final_queue",     32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
